// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU and the blocks that drive it.
//   - ALU operation codes (5-bit, as decoded by the existing ALU)
//   - div_state_t: state encoding of the sequential divider controller
//   - ALU_W / DIV_ITERS: datapath width and restoring-division step count
package alu_pkg;

  localparam int ALU_W     = 8;
  localparam int DIV_ITERS = 8;

  localparam logic [4:0] OP_AND = 5'b00000;
  localparam logic [4:0] OP_OR  = 5'b00001;
  localparam logic [4:0] OP_NOT = 5'b00010;
  localparam logic [4:0] OP_XOR = 5'b00011;
  localparam logic [4:0] OP_ADD = 5'b00100;
  localparam logic [4:0] OP_SUB = 5'b00101;
  localparam logic [4:0] OP_LSL = 5'b10000;
  localparam logic [4:0] OP_LSR = 5'b10001;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    MERGE = 3'd2,
    TRIAL = 3'd3,
    DONE  = 3'd4
  } div_state_t;

  // Zero-extends one dividend bit into an ALU operand for the OR step.
  function automatic logic [ALU_W-1:0] bit_operand(input logic b);
    return {{(ALU_W-1){1'b0}}, b};
  endfunction

endpackage

// File: rtl/div_seq.sv
// div_seq: multi-cycle unsigned 8-bit restoring divider that borrows the
// shared execute-stage ALU. Each quotient bit takes three ALU cycles:
//   SHIFT  R << 1              (LSL, result into T)
//   MERGE  T | dividend[idx]   (OR,  result into T)
//   TRIAL  T - divisor         (SUB, alu_less decides keep/restore)
// A zero divisor skips the ALU entirely and reports div_by_zero.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start               division request, honoured only in IDLE
//   dividend, divisor   operands, captured when start is accepted
//   busy                high while state != IDLE
//   done                one-cycle pulse when results are updated
//   quotient, remainder registered results, held until the next done
//   div_by_zero         registered flag, set with done for divisor == 0
//   alu_sel             high while this block owns the ALU inputs
//   alu_op, alu_a, alu_b  ALU operation and operands (0 when not owned)
//   alu_out, alu_less   combinational ALU result and unsigned in1<in2 flag
module div_seq
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [7:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [7:0] quotient,
  output logic [7:0] remainder,
  output logic       div_by_zero,
  output logic       alu_sel,
  output logic [4:0] alu_op,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  input  logic [7:0] alu_out,
  input  logic       alu_less
);

  div_state_t state, nxt;

  logic [7:0] r_q;    // partial remainder
  logic [7:0] q_q;    // quotient bits collected so far
  logic [7:0] d_q;    // captured dividend
  logic [7:0] v_q;    // captured divisor
  logic [7:0] t_q;    // ALU result carried between SHIFT/MERGE/TRIAL
  logic [2:0] idx_q;  // dividend bit consumed by the current iteration

  logic [7:0] r_trial;
  logic [7:0] q_trial;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  // Next state and ALU port drive
  always_comb begin
    nxt     = state;
    alu_sel = 1'b0;
    alu_op  = 5'b00000;
    alu_a   = 8'h00;
    alu_b   = 8'h00;
    case (state)
      IDLE: begin
        if (start) nxt = (divisor == 8'h00) ? DONE : SHIFT;
      end
      SHIFT: begin
        alu_sel = 1'b1;
        alu_op  = OP_LSL;
        alu_a   = r_q;
        alu_b   = 8'h01;
        nxt     = MERGE;
      end
      MERGE: begin
        alu_sel = 1'b1;
        alu_op  = OP_OR;
        alu_a   = t_q;
        alu_b   = bit_operand(d_q[idx_q]);
        nxt     = TRIAL;
      end
      TRIAL: begin
        alu_sel = 1'b1;
        alu_op  = OP_SUB;
        alu_a   = t_q;
        alu_b   = v_q;
        nxt     = (idx_q == 3'd0) ? DONE : SHIFT;
      end
      DONE: begin
        nxt = IDLE;
      end
      default: begin
        nxt = IDLE;
      end
    endcase
  end

  // Restoring step: keep the difference when T >= V, otherwise restore T.
  // R never exceeds 127 before a shift, so the LSL needs no carry-out.
  always_comb begin
    r_trial = alu_less ? t_q : alu_out;
    q_trial = {q_q[6:0], ~alu_less};
  end

  // Iteration registers and result capture
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q         <= 8'h00;
      q_q         <= 8'h00;
      d_q         <= 8'h00;
      v_q         <= 8'h00;
      t_q         <= 8'h00;
      idx_q       <= 3'd0;
      quotient    <= 8'h00;
      remainder   <= 8'h00;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            d_q   <= dividend;
            v_q   <= divisor;
            r_q   <= 8'h00;
            q_q   <= 8'h00;
            idx_q <= 3'd7;
            if (divisor == 8'h00) begin
              quotient    <= 8'hFF;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end
          end
        end
        SHIFT, MERGE: begin
          t_q <= alu_out;
        end
        TRIAL: begin
          r_q <= r_trial;
          q_q <= q_trial;
          if (idx_q == 3'd0) begin
            quotient    <= q_trial;
            remainder   <= r_trial;
            div_by_zero <= 1'b0;
          end else begin
            idx_q <= idx_q - 3'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_div_seq.sv
// Bench for div_seq connected to a behavioural model of the execute-stage ALU.
// Stimulus pushes expected results into a queue; a monitor pops one entry per
// done pulse and compares the registered results.
`timescale 1ns/1ps
module tb_div_seq;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] dividend, divisor;
  logic       busy, done, div_by_zero, alu_sel, alu_less;
  logic [7:0] quotient, remainder, alu_a, alu_b, alu_out;
  logic [4:0] alu_op;

  always #5 clk = ~clk;

  div_seq dut (
    .clk(clk), .reset(reset), .start(start),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero),
    .alu_sel(alu_sel), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_less(alu_less)
  );

  // Existing ALU behaviour
  always_comb begin
    case (alu_op)
      OP_AND:  alu_out = alu_a & alu_b;
      OP_OR:   alu_out = alu_a | alu_b;
      OP_NOT:  alu_out = ~alu_a;
      OP_XOR:  alu_out = alu_a ^ alu_b;
      OP_ADD:  alu_out = alu_a + alu_b;
      OP_SUB:  alu_out = alu_a - alu_b;
      OP_LSL:  alu_out = alu_a << alu_b[2:0];
      OP_LSR:  alu_out = alu_a >> alu_b[2:0];
      default: alu_out = 8'h00;
    endcase
    alu_less = (alu_a < alu_b);
  end

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       z;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   done_cnt = 0;
  logic done_prev = 1'b0;

  logic       c1_sel;
  logic [4:0] c1_op;
  logic [7:0] c1_a, c1_b;
  logic       sel_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one scoreboard entry per done pulse
  always @(negedge clk) begin
    if (!reset) begin
      if (done) begin
        exp_t e;
        done_cnt++;
        chk("done_width", {31'd0, done_prev}, 32'd0);
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got quotient %0d remainder %0d, expected no done", quotient, remainder);
        end else begin
          e = sb.pop_front();
          chk("quotient", {24'd0, quotient}, {24'd0, e.q});
          chk("remainder", {24'd0, remainder}, {24'd0, e.r});
          chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.z});
        end
      end
    end
    done_prev = done;
  end

  // Issue one division (called at a negedge, so start is sampled at edge 0),
  // scramble the operand inputs afterwards, and wait for done.
  task automatic run(input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] q, input logic [7:0] r, input logic z,
                     input int lat);
    int   n;
    logic busy_ok;
    sb.push_back('{q, r, z});
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = ~a;
    divisor  = ~b;
    n = 0;
    busy_ok  = 1'b1;
    sel_seen = 1'b0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        c1_sel = alu_sel; c1_op = alu_op; c1_a = alu_a; c1_b = alu_b;
      end
      if (!busy) busy_ok = 1'b0;
      if (alu_sel) sel_seen = 1'b1;
      if (done) break;
    end
    chk("latency", n, lat);
    chk("busy_high", {31'd0, busy_ok}, 32'd1);
    @(negedge clk);
    chk("busy_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int   n;
    int   base;
    logic [7:0] a, b;

    reset = 1'b1; start = 1'b0; dividend = 8'h00; divisor = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_quotient", {24'd0, quotient}, 32'd0);
    chk("rst_remainder", {24'd0, remainder}, 32'd0);
    chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    chk("rst_alu", {19'd0, alu_sel, alu_op, alu_a, alu_b}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // 100 / 7 = 14 r 2, plus first ALU cycle
    run(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 25);
    chk("c1_sel", {31'd0, c1_sel}, 32'd1);
    chk("c1_op", {27'd0, c1_op}, {27'd0, 5'b10000});
    chk("c1_a", {24'd0, c1_a}, 32'd0);
    chk("c1_b", {24'd0, c1_b}, 32'd1);

    run(8'd250, 8'd200, 8'd1,   8'd50, 1'b0, 25);
    run(8'd255, 8'd1,   8'd255, 8'd0,  1'b0, 25);
    run(8'd0,   8'd5,   8'd0,   8'd0,  1'b0, 25);

    // divide by zero
    run(8'd37, 8'd0, 8'hFF, 8'd37, 1'b1, 1);
    chk("dbz_no_alu", {31'd0, sel_seen}, 32'd0);

    // reset mid-operation of 200 / 9
    base = done_cnt;
    dividend = 8'd200; divisor = 8'd9; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_sel", {31'd0, alu_sel}, 32'd0);
    chk("midrst_quotient", {24'd0, quotient}, 32'd0);
    chk("midrst_remainder", {24'd0, remainder}, 32'd0);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    chk("midrst_no_done", done_cnt - base, 0);
    run(8'd200, 8'd9, 8'd22, 8'd2, 1'b0, 25);

    // starts in cycles 3 and 25 of a 100 / 7 run are ignored
    base = done_cnt;
    sb.push_back('{8'd14, 8'd2, 1'b0});
    dividend = 8'd100; divisor = 8'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      start = (n == 3 || n == 25);
      if (start) begin
        dividend = 8'd9; divisor = 8'd3;
      end
      if (done) break;
    end
    chk("ign_latency", n, 25);
    @(negedge clk);
    start = 1'b0;
    run(8'd9, 8'd3, 8'd3, 8'd0, 1'b0, 25);
    chk("ign_done_count", done_cnt - base, 2);

    // random operand pairs, every tenth divisor zero
    for (int i = 0; i < 1000; i++) begin
      a = 8'($urandom_range(0, 255));
      b = (i % 10 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      if (b == 8'd0) run(a, b, 8'hFF, a, 1'b1, 1);
      else           run(a, b, a / b, a % b, 1'b0, 25);
    end

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
